vec_cache_wdb_alloc_ctrl: RTL and testbench

Write-data-buffer (WDB) entry allocator for the vector cache write path. Holds a free list of `DB_ENTRY_NUM` WDB entries and keeps one pre-allocated entry index staged per write lane, driving the `alloc_vld/alloc_idx/alloc_rdy` handshake consumed by the 4-lane write request crossbar. Entries return through a multi-port release interface when the write data has been drained from the buffer.

---
 rtl/vec_cache_wdb_alloc_ctrl.sv | 178 +++++++++++++++++
 tb/tb_vec_cache_wdb_alloc_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cache_wdb_alloc_ctrl.sv
// Write-data-buffer entry allocator for the vector cache write path.
// Keeps a free map of DB_ENTRY_NUM entries and one staged entry index per
// write lane; staged entries are handed out on alloc_vld/alloc_rdy and
// return via the multi-port release interface.
// Optional illegal-release checking: define VEC_CACHE_WDB_ALLOC_CHK_EN.
// LANE_NUM is expected to be a power of two (rr_ptr wraps naturally).

// Per-lane staging register: loads a refill index or empties on grant.
module vec_cache_wdb_lane_stage #(
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fill,
    input  logic          grant,
    input  logic [IW-1:0] fill_idx,
    output logic          vld,
    output logic [IW-1:0] idx
);
    // Refill wins over grant so a granted lane can be restaged back-to-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            idx <= '0;
        end else if (fill) begin
            vld <= 1'b1;
            idx <= fill_idx;
        end else if (grant) begin
            vld <= 1'b0;
        end
    end
endmodule

module vec_cache_wdb_alloc_ctrl #(
    parameter int DB_ENTRY_NUM       = 32,
    parameter int LANE_NUM           = 4,
    parameter int DB_ENTRY_IDX_WIDTH = $clog2(DB_ENTRY_NUM)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    output logic [LANE_NUM-1:0]                    alloc_vld,
    output logic [LANE_NUM*DB_ENTRY_IDX_WIDTH-1:0] alloc_idx,
    input  logic [LANE_NUM-1:0]                    alloc_rdy,
    input  logic [LANE_NUM-1:0]                    rel_vld,
    input  logic [LANE_NUM*DB_ENTRY_IDX_WIDTH-1:0] rel_idx,
    output logic [$clog2(DB_ENTRY_NUM+1)-1:0]      free_cnt,
    output logic                                   all_busy
`ifdef VEC_CACHE_WDB_ALLOC_CHK_EN
    ,
    output logic                                   err_vld,
    output logic [DB_ENTRY_IDX_WIDTH-1:0]          err_idx
`endif
);
    localparam int IW = DB_ENTRY_IDX_WIDTH;
    localparam int CW = $clog2(DB_ENTRY_NUM+1);
    localparam int RW = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1;

    logic [DB_ENTRY_NUM-1:0]        free_map, free_map_nxt, avail, stg_map, rel_set;
    logic [LANE_NUM-1:0]            need, fill, grant, stg_vld_nxt;
    logic [LANE_NUM-1:0][IW-1:0]    stg_idx, fill_idx, rel_idx_a;
    logic [RW-1:0]                  rr_ptr, lane;
    logic                           unserved, found;
    logic [CW-1:0]                  cnt_nxt;

    assign grant       = alloc_vld & alloc_rdy;
    assign need        = ~alloc_vld | grant;
    assign stg_vld_nxt = fill | (alloc_vld & ~alloc_rdy);

    genvar g;
    generate
        for (g = 0; g < LANE_NUM; g++) begin : g_lane
            assign rel_idx_a[g]            = rel_idx[g*IW +: IW];
            assign alloc_idx[g*IW +: IW]   = stg_idx[g];
            vec_cache_wdb_lane_stage #(.IW(IW)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .fill     (fill[g]),
                .grant    (grant[g]),
                .fill_idx (fill_idx[g]),
                .vld      (alloc_vld[g]),
                .idx      (stg_idx[g])
            );
        end
    endgenerate

    // Rotating cascaded find-first: each needing lane, starting at rr_ptr,
    // takes the lowest registered-FREE entry not already taken this cycle
    always_comb begin
        avail    = free_map;
        fill     = '0;
        fill_idx = '0;
        unserved = 1'b0;
        lane     = '0;
        found    = 1'b0;
        for (int k = 0; k < LANE_NUM; k++) begin
            lane = rr_ptr + RW'(k);
            if (need[lane]) begin
                found = 1'b0;
                for (int e = 0; e < DB_ENTRY_NUM; e++) begin
                    if (!found && avail[e]) begin
                        found          = 1'b1;
                        fill_idx[lane] = IW'(e);
                    end
                end
                if (found) begin
                    fill[lane]            = 1'b1;
                    avail[fill_idx[lane]] = 1'b0;
                end else begin
                    unserved = 1'b1;
                end
            end
        end
    end

    // Only BUSY entries can be freed; duplicate-port releases merge via OR
    always_comb begin
        stg_map = '0;
        rel_set = '0;
        for (int i = 0; i < LANE_NUM; i++)
            if (alloc_vld[i]) stg_map[stg_idx[i]] = 1'b1;
        for (int i = 0; i < LANE_NUM; i++)
            if (rel_vld[i] && !free_map[rel_idx_a[i]] && !stg_map[rel_idx_a[i]])
                rel_set[rel_idx_a[i]] = 1'b1;
    end

    // Next free map and its popcount (registered as free_cnt)
    always_comb begin
        free_map_nxt = avail | rel_set;
        cnt_nxt      = '0;
        for (int e = 0; e < DB_ENTRY_NUM; e++)
            cnt_nxt = cnt_nxt + CW'(free_map_nxt[e]);
    end

    // Free map, status outputs and fairness pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map <= '1;
            free_cnt <= CW'(DB_ENTRY_NUM);
            all_busy <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            free_map <= free_map_nxt;
            free_cnt <= cnt_nxt;
            all_busy <= (cnt_nxt == '0) && !(|stg_vld_nxt);
            if (|need && unserved)
                rr_ptr <= rr_ptr + 1'b1;
        end
    end

`ifdef VEC_CACHE_WDB_ALLOC_CHK_EN
    logic          bad;
    logic [IW-1:0] bad_idx;

    // Illegal release: target already FREE or STAGED; lowest port reported
    always_comb begin
        bad     = 1'b0;
        bad_idx = '0;
        for (int i = LANE_NUM-1; i >= 0; i--) begin
            if (rel_vld[i] && (free_map[rel_idx_a[i]] || stg_map[rel_idx_a[i]])) begin
                bad     = 1'b1;
                bad_idx = rel_idx_a[i];
            end
        end
    end

    // Sticky error flag; index captured on first occurrence only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vld <= 1'b0;
            err_idx <= '0;
        end else begin
            err_vld <= err_vld | bad;
            if (bad && !err_vld)
                err_idx <= bad_idx;
        end
    end
`endif
endmodule

// File: tb/tb_vec_cache_wdb_alloc_ctrl.sv
// Scoreboard bench for vec_cache_wdb_alloc_ctrl: stimulus pushes expected
// output snapshots tagged with the clock edge they belong to; a monitor pops
// and compares them on the falling edge (or on demand for async reset).
module tb_vec_cache_wdb_alloc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  alloc_vld, alloc_rdy, rel_vld;
    logic [19:0] alloc_idx, rel_idx;
    logic [5:0]  free_cnt;
    logic        all_busy;
`ifdef VEC_CACHE_WDB_ALLOC_CHK_EN
    logic        err_vld;
    logic [4:0]  err_idx;
`endif

    vec_cache_wdb_alloc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_vld (alloc_vld),
        .alloc_idx (alloc_idx),
        .alloc_rdy (alloc_rdy),
        .rel_vld   (rel_vld),
        .rel_idx   (rel_idx),
        .free_cnt  (free_cnt),
        .all_busy  (all_busy)
`ifdef VEC_CACHE_WDB_ALLOC_CHK_EN
        ,
        .err_vld   (err_vld),
        .err_idx   (err_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        int          id;
        logic [3:0]  vld;
        logic [3:0]  imask;
        logic [19:0] idx;
        logic [5:0]  cnt;
        logic        busy;
        logic        ev;
        logic [4:0]  ei;
    } exp_t;

    exp_t q[$];
    int   ecnt = 0;
    int   checks = 0;
    int   failures = 0;
    logic       exp_ev = 1'b0;
    logic [4:0] exp_ei = 5'd0;
    event mon_kick;

    always @(posedge clk) ecnt++;

    function automatic logic [19:0] ix(input int a3, input int a2, input int a1, input int a0);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic report(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        failures++;
        $display("FAIL %s id=%0d got=%0h expected=%0h", name, id, got, want);
    endtask

    task automatic exp_out(input int id, input int dly, input logic [3:0] vld, input logic [3:0] imask,
                           input logic [19:0] idx, input logic [5:0] cnt, input logic busy);
        exp_t r;
        r.at = ecnt + dly; r.id = id; r.vld = vld; r.imask = imask; r.idx = idx;
        r.cnt = cnt; r.busy = busy; r.ev = exp_ev; r.ei = exp_ei;
        q.push_back(r);
    endtask

    task automatic drive(input logic [3:0] rdy, input logic [3:0] rv, input logic [19:0] ri);
        alloc_rdy = rdy;
        rel_vld   = rv;
        rel_idx   = ri;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every snapshot whose edge tag has been reached
    initial begin
        exp_t r;
        logic [19:0] m;
        forever begin
            @(negedge clk or mon_kick);
            while (q.size() > 0 && q[0].at <= ecnt) begin
                r = q.pop_front();
                checks++;
                if (r.at < ecnt) begin
                    report("stale_snapshot", r.id, 32'(ecnt), 32'(r.at));
                end else begin
                    if (alloc_vld !== r.vld) report("alloc_vld", r.id, 32'(alloc_vld), 32'(r.vld));
                    m = {{5{r.imask[3]}}, {5{r.imask[2]}}, {5{r.imask[1]}}, {5{r.imask[0]}}};
                    checks++;
                    if ((alloc_idx & m) !== (r.idx & m)) report("alloc_idx", r.id, 32'(alloc_idx & m), 32'(r.idx & m));
                    checks++;
                    if (free_cnt !== r.cnt) report("free_cnt", r.id, 32'(free_cnt), 32'(r.cnt));
                    checks++;
                    if (all_busy !== r.busy) report("all_busy", r.id, 32'(all_busy), 32'(r.busy));
`ifdef VEC_CACHE_WDB_ALLOC_CHK_EN
                    checks++;
                    if (err_vld !== r.ev) report("err_vld", r.id, 32'(err_vld), 32'(r.ev));
                    checks++;
                    if (err_idx !== r.ei) report("err_idx", r.id, 32'(err_idx), 32'(r.ei));
`endif
                end
            end
        end
    end

    // Watchdog: the directed sequence is short; anything longer is a hang
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(4'h0, 4'h0, 20'h0);
        #1;
        exp_out(0, 1, 4'h0, 4'hF, 20'h0, 6'd32, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // first edge stages entries 0..3 on lanes 0..3
        exp_out(1, 1, 4'hF, 4'hF, ix(3, 2, 1, 0), 6'd28, 1'b0);
        tick();

        // drain all 32 entries at one grant per lane per cycle
        for (int c = 1; c <= 8; c++) begin
            drive(4'hF, 4'h0, 20'h0);
            if (c < 8)
                exp_out(10 + c, 1, 4'hF, 4'hF, ix(4*c+3, 4*c+2, 4*c+1, 4*c), 6'(28 - 4*c), 1'b0);
            else
                exp_out(10 + c, 1, 4'h0, 4'h0, 20'h0, 6'd0, 1'b1);
            tick();
        end

        // exhausted: rr_ptr keeps rotating every cycle
        drive(4'h0, 4'h0, 20'h0);
        exp_out(20, 1, 4'h0, 4'h0, 20'h0, 6'd0, 1'b1);
        tick();
        exp_out(21, 1, 4'h0, 4'h0, 20'h0, 6'd0, 1'b1);
        tick();

        // single releases land on lanes 0,1,2,3 in turn
        drive(4'h0, 4'b0100, ix(0, 17, 0, 0));
        exp_out(30, 1, 4'h0, 4'h0, 20'h0, 6'd1, 1'b0);
        tick();
        drive(4'h0, 4'b1000, ix(3, 0, 0, 0));
        exp_out(31, 1, 4'b0001, 4'b0001, ix(0, 0, 0, 17), 6'd1, 1'b0);
        tick();
        drive(4'h0, 4'b0001, ix(0, 0, 0, 20));
        exp_out(32, 1, 4'b0011, 4'b0011, ix(0, 0, 3, 17), 6'd1, 1'b0);
        tick();
        drive(4'h0, 4'b0010, ix(0, 0, 31, 0));
        exp_out(33, 1, 4'b0111, 4'b0111, ix(0, 20, 3, 17), 6'd1, 1'b0);
        tick();
        drive(4'h0, 4'h0, 20'h0);
        exp_out(34, 1, 4'hF, 4'hF, ix(31, 20, 3, 17), 6'd0, 1'b0);
        tick();

        // seed four FREE entries, then sustained grants with matching releases
        drive(4'h0, 4'hF, ix(4, 2, 1, 0));
        exp_out(40, 1, 4'hF, 4'hF, ix(31, 20, 3, 17), 6'd4, 1'b0);
        tick();
        drive(4'hF, 4'hF, ix(8, 7, 6, 5));
        exp_out(41, 1, 4'hF, 4'hF, ix(0, 4, 2, 1), 6'd4, 1'b0);
        tick();
        drive(4'hF, 4'hF, ix(12, 11, 10, 9));
        exp_out(42, 1, 4'hF, 4'hF, ix(5, 8, 7, 6), 6'd4, 1'b0);
        tick();
        drive(4'hF, 4'hF, ix(31, 20, 3, 17));
        exp_out(43, 1, 4'hF, 4'hF, ix(9, 12, 11, 10), 6'd4, 1'b0);
        tick();

        // ports 0 and 3 release the same entry: counted once
        drive(4'h0, 4'b1001, ix(13, 0, 0, 13));
        exp_out(50, 1, 4'hF, 4'hF, ix(9, 12, 11, 10), 6'd5, 1'b0);
        tick();

        // release of FREE entries (13 on port 1, 3 on port 2): no state change
        drive(4'h0, 4'b0110, ix(0, 3, 13, 0));
`ifdef VEC_CACHE_WDB_ALLOC_CHK_EN
        exp_ev = 1'b1;
        exp_ei = 5'd13;
`endif
        exp_out(51, 1, 4'hF, 4'hF, ix(9, 12, 11, 10), 6'd5, 1'b0);
        tick();

        // release of STAGED entries 10 and 9: ignored, error index kept
        drive(4'h0, 4'b1001, ix(9, 0, 0, 10));
        exp_out(52, 1, 4'hF, 4'hF, ix(9, 12, 11, 10), 6'd5, 1'b0);
        tick();

        // grants refill from free {3,13,17,20,31} starting at lane 3
        drive(4'hF, 4'h0, 20'h0);
        exp_out(53, 1, 4'hF, 4'hF, ix(3, 20, 17, 13), 6'd1, 1'b0);
        tick();

        // asynchronous reset mid-traffic: outputs clear before any edge
        @(negedge clk);
        #1;
        drive(4'hF, 4'hF, ix(1, 2, 4, 5));
        rst_n  = 1'b0;
        exp_ev = 1'b0;
        exp_ei = 5'd0;
        #1;
        exp_out(60, 0, 4'h0, 4'hF, 20'h0, 6'd32, 1'b0);
        -> mon_kick;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'h0, 4'h0, 20'h0);
        exp_out(61, 1, 4'hF, 4'hF, ix(3, 2, 1, 0), 6'd28, 1'b0);
        tick();
        drive(4'hF, 4'h0, 20'h0);
        exp_out(62, 1, 4'hF, 4'hF, ix(7, 6, 5, 4), 6'd24, 1'b0);
        tick();
        drive(4'h0, 4'h0, 20'h0);
        repeat (3) tick();

        if (q.size() != 0) begin
            checks++;
            report("pending_snapshots", 99, 32'(q.size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
